// File: rtl/mult_seq_n_if.sv
// ---------------------------------------------------------------------------
// mult_seq_n_if -- operand/result bundle for the sequential multiplier.
//
// Parameters:
//   WIDTH : operand width in bits (2..32); must match the multiplier's WIDTH.
//
// Signals:
//   init : start request, an operation begins on its 0->1 transition
//   sgn  : 1 = signed (two's-complement) operands, 0 = unsigned
//   A    : multiplicand, WIDTH bits
//   B    : multiplier, WIDTH bits
//   pp   : product, 2*WIDTH bits, held until the next result
//   busy : operation in progress
//   done : one-cycle pulse when pp carries a fresh result
//
// Modports:
//   master : the requester (drives init/sgn/A/B)
//   slave  : the multiplier (drives pp/busy/done)
// ---------------------------------------------------------------------------
interface mult_seq_n_if #(
    parameter int WIDTH = 16
);
    logic                 init;
    logic                 sgn;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   pp;
    logic                 busy;
    logic                 done;

    modport master (
        output init, sgn, A, B,
        input  pp, busy, done
    );

    modport slave (
        input  init, sgn, A, B,
        output pp, busy, done
    );
endinterface

// File: rtl/mult_seq_n.sv
// ---------------------------------------------------------------------------
// mult_seq_n -- sequential shift-and-add multiplier, signed or unsigned.
//
// A start request (rising edge of init) captures A, B and sgn. The operands
// are converted to magnitudes, multiplied one multiplier bit per clock, and
// the sign is re-applied in a final fix-up step. The product is registered
// and held until the next result; done pulses for one cycle with it.
//
// Parameters:
//   WIDTH : operand width, 2..32 (default 16)
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous, active-low reset
//   bus : mult_seq_n_if.slave (init, sgn, A, B in; pp, busy, done out)
//
// Optional feature:
//   MULT_EARLY_EXIT_EN : when defined, the RUN phase ends as soon as the
//   remaining multiplier bits are all zero. The product is unchanged; only
//   the latency shrinks. Undefined by default (RUN lasts WIDTH cycles).
// ---------------------------------------------------------------------------
module mult_seq_n #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    mult_seq_n_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t            state_q;
    logic              initPrev_q;
    logic [WIDTH-1:0]  aCap_q;
    logic [WIDTH-1:0]  bCap_q;
    logic              sgnCap_q;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic [PW-1:0]     pp_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  magA_d;
    logic [WIDTH-1:0]  magB_d;
    logic              neg_d;
    logic [PW-1:0]     accSum_d;
    logic [WIDTH-1:0]  mplierShift_d;
    logic              lastIter_d;
    logic              startReq_d;

    // Operand preparation, one accumulation step and the RUN exit test.
    // Negating the most negative value in WIDTH bits wraps to 2^(WIDTH-1),
    // which read as unsigned is exactly the magnitude we need, so no extra
    // bit is required for the magnitudes.
    always_comb begin
        magA_d        = aCap_q;
        magB_d        = bCap_q;
        neg_d         = 1'b0;
        if (sgnCap_q) begin
            if (aCap_q[WIDTH-1]) begin
                magA_d = WIDTH'(-aCap_q);
            end
            if (bCap_q[WIDTH-1]) begin
                magB_d = WIDTH'(-bCap_q);
            end
            neg_d = aCap_q[WIDTH-1] ^ bCap_q[WIDTH-1];
        end

        accSum_d      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplierShift_d = mplier_q >> 1;
        startReq_d    = bus.init & ~initPrev_q;

`ifdef MULT_EARLY_EXIT_EN
        lastIter_d    = (cnt_q == CW'(1)) || (mplierShift_d == '0);
`else
        lastIter_d    = (cnt_q == CW'(1));
`endif
    end

    // Control FSM and datapath registers. initPrev_q resets to 1 so that an
    // init held high through reset is not mistaken for a fresh request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            initPrev_q <= 1'b1;
            aCap_q     <= '0;
            bCap_q     <= '0;
            sgnCap_q   <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            pp_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            initPrev_q <= bus.init;
            done_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (startReq_d) begin
                        aCap_q   <= bus.A;
                        bCap_q   <= bus.B;
                        sgnCap_q <= bus.sgn;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end

                LOAD: begin
                    mcand_q  <= {{WIDTH{1'b0}}, magA_d};
                    mplier_q <= magB_d;
                    neg_q    <= neg_d;
                    acc_q    <= '0;
                    cnt_q    <= CW'(WIDTH);
                    state_q  <= RUN;
                end

                RUN: begin
                    acc_q    <= accSum_d;
                    mplier_q <= mplierShift_d;
                    mcand_q  <= mcand_q << 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (lastIter_d) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    pp_q    <= neg_q ? (PW'(0) - acc_q) : acc_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pp   = pp_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mult_seq_n.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_n -- scoreboard bench for mult_seq_n at WIDTH=4 and WIDTH=16.
// Each start pushes the hand-computed product and the edge number at which
// done must appear; a monitor per instance pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_mult_seq_n;

    typedef struct {
        logic [63:0] pp;
        int          edgeNo;
    } expT;

    logic clk;
    logic rst;
    int   cycleCnt;
    int   checkCount;
    int   badCount;

    expT  q4[$];
    expT  q16[$];
    expT  e4;
    expT  e16;

    mult_seq_n_if #(.WIDTH(4))  bus4 ();
    mult_seq_n_if #(.WIDTH(16)) bus16 ();

    mult_seq_n #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    mult_seq_n #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time done against the start edge.
    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt = cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checkCount = checkCount + 1;
        if (act !== exp) begin
            badCount = badCount + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected number of edges from the start edge to the done edge.
    function automatic int expLat(input int width, input logic [31:0] b,
                                  input logic s);
`ifdef MULT_EARLY_EXIT_EN
        longint mask;
        longint mag;
        int     len;
        mask = (64'd1 << width) - 1;
        mag  = longint'(b) & mask;
        if (s && b[width-1]) mag = (-mag) & mask;
        len = 0;
        for (int i = 0; i < width; i++) if (mag[i]) len = i + 1;
        if (len == 0) len = 1;
        return len + 2;
`else
        return width + 2;
`endif
    endfunction

    // WIDTH=4 monitor: every done must match the oldest expectation.
    always @(negedge clk) begin
        if (bus4.done) begin
            if (q4.size() == 0) begin
                checkOutput("unexpectedDone4", 64'd1, 64'd0);
            end else begin
                e4 = q4.pop_front();
                checkOutput("pp4", 64'(bus4.pp), e4.pp);
                checkOutput("doneEdge4", 64'(cycleCnt), 64'(e4.edgeNo));
                checkOutput("busyAtDone4", 64'(bus4.busy), 64'd0);
            end
        end
    end

    // WIDTH=16 monitor, same scheme.
    always @(negedge clk) begin
        if (bus16.done) begin
            if (q16.size() == 0) begin
                checkOutput("unexpectedDone16", 64'd1, 64'd0);
            end else begin
                e16 = q16.pop_front();
                checkOutput("pp16", 64'(bus16.pp), e16.pp);
                checkOutput("doneEdge16", 64'(cycleCnt), 64'(e16.edgeNo));
                checkOutput("busyAtDone16", 64'(bus16.busy), 64'd0);
            end
        end
    end

    // Start one WIDTH=4 operation; init stays high for holdCycles cycles.
    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b,
                                  input logic s, input logic [7:0] exp,
                                  input int holdCycles);
        expT e;
        @(negedge clk);
        bus4.A    = a;
        bus4.B    = b;
        bus4.sgn  = s;
        bus4.init = 1'b1;
        e.pp      = 64'(exp);
        e.edgeNo  = cycleCnt + 1 + expLat(4, 32'(b), s);
        q4.push_back(e);
        repeat (holdCycles) @(negedge clk);
        bus4.init = 1'b0;
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic [31:0] exp);
        expT e;
        @(negedge clk);
        bus16.A    = a;
        bus16.B    = b;
        bus16.sgn  = s;
        bus16.init = 1'b1;
        e.pp       = 64'(exp);
        e.edgeNo   = cycleCnt + 1 + expLat(16, 32'(b), s);
        q16.push_back(e);
        @(negedge clk);
        bus16.init = 1'b0;
    endtask

    // Wait until both scoreboards drain and both instances are idle.
    task automatic waitIdle();
        logic timedOut;
        timedOut = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (q4.size() == 0 && q16.size() == 0 && !bus4.busy && !bus16.busy) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("idleTimeout", 64'(timedOut), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Directed sequence.
    initial begin
        checkCount = 0;
        badCount   = 0;
        rst        = 1'b0;
        bus4.init  = 1'b1;
        bus4.sgn   = 1'b0;
        bus4.A     = '0;
        bus4.B     = '0;
        bus16.init = 1'b0;
        bus16.sgn  = 1'b0;
        bus16.A    = '0;
        bus16.B    = '0;

        repeat (3) @(negedge clk);
        checkOutput("rstPp4", 64'(bus4.pp), 64'd0);
        checkOutput("rstBusy4", 64'(bus4.busy), 64'd0);
        checkOutput("rstDone4", 64'(bus4.done), 64'd0);
        checkOutput("rstPp16", 64'(bus16.pp), 64'd0);
        checkOutput("rstBusy16", 64'(bus16.busy), 64'd0);

        // init held high across reset release must not start anything.
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("heldInitBusy4", 64'(bus4.busy), 64'd0);
        bus4.init = 1'b0;
        @(negedge clk);

        // Unsigned 5*3 with init held three cycles: exactly one result.
        applyStimulus4(4'd5, 4'd3, 1'b0, 8'h0F, 3);
        waitIdle();
        repeat (4) @(negedge clk);
        checkOutput("ppHold4", 64'(bus4.pp), 64'h0F);

        // Signed and unsigned corner vectors at WIDTH=4.
        applyStimulus4(4'hB, 4'h3, 1'b1, 8'hF1, 1);
        waitIdle();
        applyStimulus4(4'h8, 4'h8, 1'b1, 8'h40, 1);
        waitIdle();
        applyStimulus4(4'hF, 4'hF, 1'b0, 8'hE1, 1);
        waitIdle();
        applyStimulus4(4'h7, 4'h8, 1'b1, 8'hC8, 1);
        waitIdle();
        applyStimulus4(4'hF, 4'hF, 1'b1, 8'h01, 1);
        waitIdle();
        applyStimulus4(4'h0, 4'h9, 1'b0, 8'h00, 1);
        waitIdle();
        applyStimulus4(4'hF, 4'h1, 1'b1, 8'hFF, 1);
        waitIdle();

        // WIDTH=16 vectors.
        applyStimulus16(16'hFA00, 16'hFA00, 1'b0, 32'hF4240000);
        waitIdle();
        applyStimulus16(16'd200, 16'd3, 1'b0, 32'h00000258);
        waitIdle();
        applyStimulus16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        waitIdle();
        applyStimulus16(16'hFFFF, 16'h7FFF, 1'b1, 32'hFFFF8001);
        waitIdle();
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        waitIdle();
        applyStimulus16(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
        waitIdle();

        // New init edge and operand changes while busy are ignored.
        applyStimulus4(4'd6, 4'd2, 1'b0, 8'h0C, 1);
        bus4.A = 4'd9;
        bus4.B = 4'd9;
        bus4.sgn = 1'b1;
        @(negedge clk);
        bus4.init = 1'b1;
        repeat (2) @(negedge clk);
        bus4.init = 1'b0;
        waitIdle();

        // Reset in the middle of RUN aborts the operation without done.
        applyStimulus4(4'd5, 4'd5, 1'b0, 8'h19, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q4.delete();
        #1;
        checkOutput("abortBusy4", 64'(bus4.busy), 64'd0);
        checkOutput("abortDone4", 64'(bus4.done), 64'd0);
        checkOutput("abortPp4", 64'(bus4.pp), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postAbortPp4", 64'(bus4.pp), 64'd0);
        applyStimulus4(4'd7, 4'd7, 1'b0, 8'h31, 1);
        waitIdle();

        $display("test done: total=%0d bad=%0d", checkCount, badCount);
        $finish;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/mult_seq_n.md
MULT_SEQ_N -- requirements
Module: mult_seq_n

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 init  input  1  start request; a 0->1 transition (edge-detected) starts an operation.
REQ-005 sgn  input  1  mode; 1 = two's-complement signed operands, 0 = unsigned; sampled with init.
REQ-006 A  input  WIDTH  multiplicand.
REQ-007 B  input  WIDTH  multiplier.
REQ-008 pp  output  2*WIDTH  product; registered, held until next result.
REQ-009 busy  output  1  high from the start-sampling edge until the edge entering DONE.
REQ-010 done  output  1  single-cycle pulse when pp is valid.

Function
REQ-011 FSM states IDLE, LOAD, RUN, FIX, DONE; one state per clock.
REQ-012 IDLE: on an edge where init=1 and the previous registered init=0, capture A, B, sgn; go to LOAD; busy=1.
REQ-013 A level-held init starts exactly one operation; a new start requires init to return low.
REQ-014 LOAD: form |A|, |B| (sign-magnitude when sgn=1, raw when sgn=0); neg flag = sign(A) XOR sign(B) when sgn=1, else 0; accumulator=0; counter=WIDTH; go to RUN.
REQ-015 RUN: per cycle, if multiplier LSB=1 add shifted multiplicand to accumulator; shift multiplier right, multiplicand left; decrement counter; exit to FIX when counter reaches 0.
REQ-016 Accumulator is 2*WIDTH bits; no intermediate overflow possible; no truncation.
REQ-017 FIX: pp <= neg ? two's-complement negation of accumulator : accumulator; go to DONE.
REQ-018 DONE: done=1, busy=0 for exactly one cycle; then IDLE.
REQ-019 Latency (macro off): done high at the WIDTH+2 rising edge after the start-sampling edge.
REQ-020 init edges, A, B, sgn changes while busy=1 or in DONE are ignored; operands are the ones captured at start.
REQ-021 Signed -2^(WIDTH-1) operand is handled via WIDTH-bit magnitude 2^(WIDTH-1); (-2^(W-1))*(-2^(W-1)) yields +2^(2W-2) exactly.
REQ-022 pp is unchanged outside FIX; back-to-back operations allowed, next start accepted from IDLE.

Reset
REQ-023 rst=0 asynchronously forces IDLE, pp=0, done=0, busy=0, accumulator=0, counter=0, registered init=1 (init held high across reset does not start an operation).
REQ-024 Reset mid-operation aborts it; no done pulse; pp=0 after release.

Configuration
REQ-025 Macro MULT_EARLY_EXIT_EN: when defined, RUN also exits to FIX after the iteration that leaves the shifted multiplier equal to zero; RUN length = max(1, bit-length of |B|).
REQ-026 Without MULT_EARLY_EXIT_EN, RUN always lasts exactly WIDTH cycles, independent of operands.
REQ-027 pp value is identical with and without the macro; only latency differs.

Verification
REQ-028 WIDTH=4, sgn=0, A=5, B=3, init 0->1 held 3 cycles -> one done pulse at edge 6 after start, pp=15, no second operation.
REQ-029 WIDTH=4, sgn=1, A=4'hB (-5), B=3 -> pp=8'hF1 (-15); A=4'h8, B=4'h8 -> pp=8'h40 (+64).
REQ-030 WIDTH=16, sgn=0, A=16'hFA00, B=16'hFA00 -> pp=32'hF4240000, done at edge 18.
REQ-031 WIDTH=4, rst driven low at RUN cycle 2 -> busy=0, done never pulses, pp=0; next start with A=7, B=7 -> pp=49.
REQ-032 MULT_EARLY_EXIT_EN, WIDTH=8, sgn=0, A=200, B=3 -> pp=600, done at edge 4; B=0 -> pp=0, done at edge 3.
REQ-033 WIDTH=4, second init edge and changed A/B during busy -> ignored, pp matches first operands.
